// File: rtl/cpu_ctrl_fsm_v2.sv
// Multi-cycle CPU control FSM: fetch, decode, ALU/MOV/LDR/STR/branch sequencing.
// Memory waits are bounded by MEM_TIMEOUT; HALT and ERR are left only through reset.
//
// state    | meaning
// RST      | reset PC
// IF       | fetch, wait for mem_ready
// UPD_PC   | PC <= PC+1
// DECODE   | dispatch on {opcode,op}
// GET_A..WR_REG       | ALU op (CMP skips write)
// MOV_IMM, MOV1..MOV3 | move immediate / register
// MEM_A..ST_WAIT      | LDR/STR address, wait, writeback
// BR, BL_LINK         | conditional branch, branch-and-link
// BX_B, BX_C, BX_PC   | branch to register
// HALT, ERR           | absorbing
module cpu_ctrl_fsm_v2 #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit BRANCH_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       N,
  input  logic       V,
  input  logic       Z,
  input  logic       mem_ready,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic [1:0] mem_cmd,
  output logic [1:0] pc_sel,
  output logic       halted,
  output logic       err
);

  typedef enum logic [4:0] {
    S_RST, S_IF, S_UPD_PC, S_DECODE,
    S_GET_A, S_GET_B, S_ALU, S_WR_REG,
    S_MOV_IMM, S_MOV1, S_MOV2, S_MOV3,
    S_MEM_A, S_MEM_ADD, S_MEM_ADDR, S_LD_WAIT, S_LD_WB, S_ST_B, S_ST_WAIT,
    S_BR, S_BL_LINK, S_BX_B, S_BX_C, S_BX_PC,
    S_HALT, S_ERR
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       wait_tmo;
  logic       br_legal;
  logic       br_taken;

  assign waiting  = (state == S_IF) || (state == S_LD_WAIT) || (state == S_ST_WAIT);
  assign wait_tmo = (wait_cnt == TMO_LAST);
  assign br_legal = (cond <= 3'b100);

  always_comb begin
    br_taken = 1'b0;
    case (cond)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = Z;
      3'b010:  br_taken = !Z;
      3'b011:  br_taken = (N != V);
      3'b100:  br_taken = (N != V) || Z;
      default: br_taken = 1'b0;
    endcase
  end

  // Counter restarts on every state change so each wait state gets a fresh budget.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_RST;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        wait_cnt <= '0;
      else if (waiting && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_RST:      state_nx = S_IF;
      S_IF:       if (mem_ready) state_nx = S_UPD_PC;
                  else if (wait_tmo) state_nx = S_ERR;
      S_UPD_PC:   state_nx = S_DECODE;
      S_DECODE: begin
        casez ({opcode, op})
          5'b11010: state_nx = S_MOV_IMM;
          5'b11000: state_nx = S_MOV1;
          5'b101??: state_nx = S_GET_A;
          5'b01100: state_nx = S_MEM_A;
          5'b10000: state_nx = S_MEM_A;
          5'b111??: state_nx = S_HALT;
          5'b00100: state_nx = BRANCH_EN ? S_BR      : S_ERR;
          5'b01011: state_nx = BRANCH_EN ? S_BL_LINK : S_ERR;
          5'b01000: state_nx = BRANCH_EN ? S_BX_B    : S_ERR;
          default:  state_nx = S_ERR;
        endcase
      end
      S_GET_A:    state_nx = S_GET_B;
      S_GET_B:    state_nx = S_ALU;
      S_ALU:      state_nx = S_WR_REG;
      S_WR_REG:   state_nx = S_IF;
      S_MOV_IMM:  state_nx = S_IF;
      S_MOV1:     state_nx = S_MOV2;
      S_MOV2:     state_nx = S_MOV3;
      S_MOV3:     state_nx = S_IF;
      S_MEM_A:    state_nx = S_MEM_ADD;
      S_MEM_ADD:  state_nx = S_MEM_ADDR;
      S_MEM_ADDR: state_nx = (opcode == 3'b011) ? S_LD_WAIT : S_ST_B;
      S_LD_WAIT:  if (mem_ready) state_nx = S_LD_WB;
                  else if (wait_tmo) state_nx = S_ERR;
      S_LD_WB:    state_nx = S_IF;
      S_ST_B:     state_nx = S_ST_WAIT;
      S_ST_WAIT:  if (mem_ready) state_nx = S_IF;
                  else if (wait_tmo) state_nx = S_ERR;
      S_BR:       state_nx = br_legal ? S_IF : S_ERR;
      S_BL_LINK:  state_nx = S_IF;
      S_BX_B:     state_nx = S_BX_C;
      S_BX_C:     state_nx = S_BX_PC;
      S_BX_PC:    state_nx = S_IF;
      S_HALT:     state_nx = S_HALT;
      S_ERR:      state_nx = S_ERR;
      default:    state_nx = S_ERR;
    endcase
  end

  always_comb begin
    loada = 1'b0; loadb = 1'b0; asel = 1'b0; bsel = 1'b0;
    loadc = 1'b0; loads = 1'b0; write = 1'b0; load_ir = 1'b0;
    load_pc = 1'b0; reset_pc = 1'b0; addr_sel = 1'b0; load_addr = 1'b0;
    nsel = 3'b000; vsel = 4'b0000; mem_cmd = 2'b00; pc_sel = 2'b00;
    halted = 1'b0; err = 1'b0;
    unique case (state)
      S_RST:      begin reset_pc = 1'b1; load_pc = 1'b1; end
      S_IF:       begin addr_sel = 1'b1; mem_cmd = 2'b01; load_ir = mem_ready; end
      S_UPD_PC:   begin load_pc = 1'b1; pc_sel = 2'b00; end
      S_DECODE:   ;
      S_GET_A:    begin nsel = 3'b100; loada = 1'b1; end
      S_GET_B:    begin nsel = 3'b001; loadb = 1'b1; end
      S_ALU:      begin loadc = 1'b1; loads = 1'b1; end
      S_WR_REG: begin
        if (op != 2'b01) begin
          nsel = 3'b010; vsel = 4'b0001; write = 1'b1;
        end
      end
      S_MOV_IMM:  begin nsel = 3'b100; vsel = 4'b0100; write = 1'b1; end
      S_MOV1:     begin nsel = 3'b001; loadb = 1'b1; end
      S_MOV2:     begin asel = 1'b1; loadc = 1'b1; end
      S_MOV3:     begin nsel = 3'b010; vsel = 4'b0001; write = 1'b1; end
      S_MEM_A:    begin nsel = 3'b100; loada = 1'b1; end
      S_MEM_ADD:  begin bsel = 1'b1; loadc = 1'b1; end
      S_MEM_ADDR: load_addr = 1'b1;
      S_LD_WAIT:  mem_cmd = 2'b01;
      S_LD_WB:    begin nsel = 3'b010; vsel = 4'b1000; write = 1'b1; end
      S_ST_B:     begin nsel = 3'b010; loadb = 1'b1; end
      S_ST_WAIT:  begin mem_cmd = 2'b10; asel = 1'b1; loadc = 1'b1; end
      S_BR: begin
        if (br_legal && br_taken) begin
          load_pc = 1'b1; pc_sel = 2'b01;
        end
      end
      S_BL_LINK: begin
        nsel = 3'b100; vsel = 4'b0010; write = 1'b1;
        load_pc = 1'b1; pc_sel = 2'b01;
      end
      S_BX_B:     begin nsel = 3'b010; loadb = 1'b1; end
      S_BX_C:     begin asel = 1'b1; loadc = 1'b1; end
      S_BX_PC:    begin load_pc = 1'b1; pc_sel = 2'b10; end
      S_HALT:     halted = 1'b1;
      S_ERR:      err = 1'b1;
      default:    err = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm_v2.sv
// Scoreboard bench: tests queue the expected strobe events; a negedge monitor
// compares every observed event (and cycles since the previous one) in order.
module tb_cpu_ctrl_fsm_v2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic [2:0] cond = 3'b000;
  logic       N = 1'b0, V = 1'b0, Z = 1'b0;
  logic       mem_ready = 1'b1;
  logic       loada, loadb, asel, bsel, loadc, loads, write, load_ir;
  logic       load_pc, reset_pc, addr_sel, load_addr, halted, err;
  logic [2:0] nsel;
  logic [3:0] vsel;
  logic [1:0] mem_cmd, pc_sel;

  cpu_ctrl_fsm_v2 #(.MEM_TIMEOUT(4), .BRANCH_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
    .N(N), .V(V), .Z(Z), .mem_ready(mem_ready),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .loadc(loadc),
    .loads(loads), .write(write), .load_ir(load_ir), .load_pc(load_pc),
    .reset_pc(reset_pc), .addr_sel(addr_sel), .load_addr(load_addr),
    .nsel(nsel), .vsel(vsel), .mem_cmd(mem_cmd), .pc_sel(pc_sel),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          gap;
    logic [17:0] v;
  } exp_t;

  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;
  string tname = "init";

  // {write, nsel, vsel, load_pc, reset_pc, pc_sel, load_ir, load_addr, err, halted, mem_cmd}
  function automatic logic [17:0] mk(logic wr, logic [2:0] ns, logic [3:0] vs, logic lpc,
                                     logic rpc, logic [1:0] ps, logic lir, logic lad,
                                     logic er, logic ht, logic [1:0] mc);
    return {wr, ns, vs, lpc, rpc, ps, lir, lad, er, ht, mc};
  endfunction

  task automatic push(int g, logic [17:0] v);
    exp_t e;
    e.gap = g;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic p_rst(int g);  push(g, mk(0, 3'b000, 4'b0000, 1, 1, 2'b00, 0, 0, 0, 0, 2'b00)); endtask
  task automatic p_if(int g);   push(g, mk(0, 3'b000, 4'b0000, 0, 0, 2'b00, 1, 0, 0, 0, 2'b01)); endtask
  task automatic p_upd(int g);  push(g, mk(0, 3'b000, 4'b0000, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00)); endtask
  task automatic p_halt(int g); push(g, mk(0, 3'b000, 4'b0000, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00)); endtask
  task automatic p_err(int g);  push(g, mk(0, 3'b000, 4'b0000, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00)); endtask
  task automatic p_lad(int g);  push(g, mk(0, 3'b000, 4'b0000, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00)); endtask
  task automatic p_mem(int g, logic [1:0] mc);
    push(g, mk(0, 3'b000, 4'b0000, 0, 0, 2'b00, 0, 0, 0, 0, mc));
  endtask
  task automatic p_wr(int g, logic [2:0] ns, logic [3:0] vs);
    push(g, mk(1, ns, vs, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00));
  endtask
  task automatic p_tail();
    p_if(1); p_upd(1); p_halt(2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset 2 cycles, fetch, PC update, decode; returns just after the decode edge.
  task automatic start(string n, logic [2:0] opc, logic [1:0] o);
    tname = n;
    p_rst(0); p_rst(1); p_if(1); p_upd(1);
    reset = 1'b0; mem_ready = 1'b1; opcode = opc; op = o;
    tick();
    mon_en = 1'b1;
    tick();
    reset = 1'b1;
    repeat (4) tick();
  endtask

  task automatic finish_test();
    repeat (10) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending: %0d expected events not seen, want 0", tname, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin : monitor
    int   gap_cnt;
    logic err_q, halted_q;
    logic [17:0] obs;
    logic ev;
    exp_t e;
    gap_cnt = 0; err_q = 1'b0; halted_q = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        obs = mk(write, nsel, vsel, load_pc, reset_pc, pc_sel, load_ir, load_addr, err, halted, mem_cmd);
        ev  = write | load_pc | load_ir | load_addr | (mem_cmd != 2'b00) |
              (err & !err_q) | (halted & !halted_q);
        gap_cnt++;
        if (ev) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected event: got v=%h gap=%0d, want none", tname, obs, gap_cnt);
          end else begin
            e = exp_q.pop_front();
            if (obs !== e.v || (e.gap != 0 && gap_cnt != e.gap)) begin
              errors++;
              $display("FAIL %s event: got v=%h gap=%0d, want v=%h gap=%0d",
                       tname, obs, gap_cnt, e.v, e.gap);
            end
          end
          gap_cnt = 0;
        end
        err_q    = err;
        halted_q = halted;
      end
    end
  end

  task automatic br_case(logic [2:0] c, logic n, logic v, logic z, int kind);
    N = n; V = v; Z = z; cond = c;
    start($sformatf("br_c%b_nvz%b%b%b", c, n, v, z), 3'b001, 2'b00);
    opcode = 3'b111;
    case (kind)
      1:       begin push(2, mk(0, 3'b000, 4'b0000, 1, 0, 2'b01, 0, 0, 0, 0, 2'b00)); p_tail(); end
      2:       p_err(3);
      default: begin p_if(3); p_upd(1); p_halt(2); end
    endcase
    finish_test();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    start("halt", 3'b111, 2'b00);
    p_halt(2);
    finish_test();

    start("add", 3'b101, 2'b00);
    opcode = 3'b111;
    p_wr(5, 3'b010, 4'b0001); p_tail();
    finish_test();

    start("cmp", 3'b101, 2'b01);
    opcode = 3'b111;
    p_if(6); p_upd(1); p_halt(2);
    finish_test();

    start("mov_imm", 3'b110, 2'b10);
    opcode = 3'b111;
    p_wr(2, 3'b100, 4'b0100); p_tail();
    finish_test();

    start("mov_reg", 3'b110, 2'b00);
    opcode = 3'b111;
    p_wr(4, 3'b010, 4'b0001); p_tail();
    finish_test();

    start("ldr_wait", 3'b011, 2'b00);
    p_lad(4);
    for (int i = 0; i < 4; i++) p_mem(1, 2'b01);
    p_wr(1, 3'b010, 4'b1000); p_tail();
    tick(); tick(); tick();
    mem_ready = 1'b0; opcode = 3'b111;
    tick(); tick(); tick();
    mem_ready = 1'b1;
    finish_test();

    start("str_timeout", 3'b100, 2'b00);
    p_lad(4); p_mem(2, 2'b10);
    for (int i = 0; i < 3; i++) p_mem(1, 2'b10);
    p_err(1);
    tick(); tick(); tick();
    mem_ready = 1'b0;
    finish_test();

    br_case(3'b001, 1'b0, 1'b0, 1'b1, 1);
    br_case(3'b001, 1'b0, 1'b0, 1'b0, 0);
    br_case(3'b110, 1'b0, 1'b0, 1'b1, 2);
    br_case(3'b011, 1'b1, 1'b0, 1'b0, 1);
    br_case(3'b100, 1'b0, 1'b0, 1'b0, 0);
    br_case(3'b010, 1'b0, 1'b0, 1'b0, 1);

    start("bl", 3'b010, 2'b11);
    opcode = 3'b111;
    push(2, mk(1, 3'b100, 4'b0010, 1, 0, 2'b01, 0, 0, 0, 0, 2'b00)); p_tail();
    finish_test();

    start("bx", 3'b010, 2'b00);
    opcode = 3'b111;
    push(4, mk(0, 3'b000, 4'b0000, 1, 0, 2'b10, 0, 0, 0, 0, 2'b00)); p_tail();
    finish_test();

    start("illegal", 3'b000, 2'b00);
    p_err(2);
    finish_test();

    start("reset_mid_ld", 3'b011, 2'b00);
    p_lad(4); p_mem(1, 2'b01); p_mem(1, 2'b01); p_rst(1); p_tail();
    tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; mem_ready = 1'b1; opcode = 3'b111;
    finish_test();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
